// File: rtl/hc_pkg.sv
// Shared types and default sizing for the 74HC165 reader (and its 74HC595 sibling).
// FSM state encoding plus default chain width and shift-clock divider.
package hc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH
    } state_t;

    localparam int unsigned HC_DATA_W  = 16;
    localparam int unsigned HC_CLK_DIV = 4;

endpackage

// File: rtl/hc_tick_gen.sv
// Clearable divider: emits a one-cycle tick every CLK_DIV cycles of clk.
// The count is held at 0 while clr is high.
module hc_tick_gen
    import hc_pkg::*;
#(
    parameter int unsigned CLK_DIV = HC_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hc165_reader.sv
// Drives a 74HC165 chain (pl_n, sh_clk) and returns the captured word MSB first.
// Define HC165_DEBOUNCE_EN to publish a word only after two identical reads in a row.
module hc165_reader
    import hc_pkg::*;
#(
    parameter int unsigned DATA_W  = HC_DATA_W,
    parameter int unsigned CLK_DIV = HC_CLK_DIV
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              q7,
    output logic              pl_n,
    output logic              sh_clk,
    output logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    state_t            state, state_nx;
    logic              q7_meta, q7_sync;
    logic              tick, tick_clr;
    logic [DATA_W-1:0] shreg, shreg_nx, data_nx;
    logic [BW-1:0]     bit_cnt, bit_cnt_nx;
    logic              pl_n_nx, sh_clk_nx, busy_nx, dv_nx;
`ifdef HC165_DEBOUNCE_EN
    logic [DATA_W-1:0] prev_raw, prev_raw_nx;
`endif

    assign tick_clr = (state == IDLE) || !en;

    hc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk_50mhz),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            q7_meta <= 1'b0;
            q7_sync <= 1'b0;
        end else begin
            q7_meta <= q7;
            q7_sync <= q7_meta;
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_cnt_nx  = bit_cnt;
        pl_n_nx     = pl_n;
        sh_clk_nx   = sh_clk;
        busy_nx     = busy;
        dv_nx       = 1'b0;
        data_nx     = data;
`ifdef HC165_DEBOUNCE_EN
        prev_raw_nx = prev_raw;
`endif
        if (!en) begin
            state_nx  = IDLE;
            pl_n_nx   = 1'b1;
            sh_clk_nx = 1'b0;
            busy_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pl_n_nx   = 1'b1;
                    sh_clk_nx = 1'b0;
                    if (start) begin
                        state_nx   = LOAD;
                        pl_n_nx    = 1'b0;
                        busy_nx    = 1'b1;
                        bit_cnt_nx = '0;
                    end
                end
                LOAD: if (tick) begin
                    state_nx = LOW;
                    pl_n_nx  = 1'b1;
                end
                // Sample on the same edge sh_clk rises, before the chain shifts.
                LOW: if (tick) begin
                    shreg_nx   = {shreg[DATA_W-2:0], q7_sync};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    sh_clk_nx  = 1'b1;
                    state_nx   = HIGH;
                end
                HIGH: if (tick) begin
                    sh_clk_nx = 1'b0;
                    if (bit_cnt == BW'(DATA_W)) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
`ifdef HC165_DEBOUNCE_EN
                        prev_raw_nx = shreg;
                        if (shreg == prev_raw) begin
                            data_nx = shreg;
                            dv_nx   = 1'b1;
                        end
`else
                        data_nx = shreg;
                        dv_nx   = 1'b1;
`endif
                    end else begin
                        state_nx = LOW;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            pl_n       <= 1'b1;
            sh_clk     <= 1'b0;
            busy       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_cnt    <= bit_cnt_nx;
            pl_n       <= pl_n_nx;
            sh_clk     <= sh_clk_nx;
            busy       <= busy_nx;
            data       <= data_nx;
            data_valid <= dv_nx;
        end
    end

`ifdef HC165_DEBOUNCE_EN
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw <= '0;
        end else begin
            prev_raw <= prev_raw_nx;
        end
    end
`endif

endmodule
